// File: rtl/lab3_cache_mem_port_arbiter_if.sv
// lab3_cache_mem_port_arbiter_if: val/rdy/msg handshake channel
interface lab3_cache_mem_port_arbiter_if #(parameter int W = 77);
  logic val;
  logic rdy;
  logic [W-1:0] msg;
  modport master (output val, output msg, input rdy);
  modport slave (input val, input msg, output rdy);
endinterface

// File: rtl/lab3_cache_mem_port_arbiter.sv
// lab3_cache_mem_port_arbiter: shares one memory port between I$ (port 0) and D$ (port 1), one transaction at a time
module lab3_cache_mem_port_arbiter #(
  parameter bit p_fixed_prio = 1'b0,
  parameter bit p_init_prio = 1'b0
) (
  input logic clk,
  input logic reset,
  lab3_cache_mem_port_arbiter_if.slave req0,
  lab3_cache_mem_port_arbiter_if.master resp0,
  lab3_cache_mem_port_arbiter_if.slave req1,
  lab3_cache_mem_port_arbiter_if.master resp1,
  lab3_cache_mem_port_arbiter_if.master mem_req,
  lab3_cache_mem_port_arbiter_if.slave mem_resp,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;
  state_t state;
  logic grant_id, prio, rst_d, go, win1;
  logic mem_req_val_q, mem_resp_rdy_q, busy_q;
  logic [1:0] resp_val_q;
  logic [76:0] req_buf;
  logic [46:0] resp_buf;
  logic mem_req_val, resp0_val, resp1_val;
  // Grant only in IDLE, never during reset or the cycle right after it
  always_comb begin
    go = (state == IDLE) & ~reset & ~rst_d;
    win1 = req1.val & (~req0.val | (~p_fixed_prio & prio));
  end
  assign req0.rdy = go & req0.val & ~win1;
  assign req1.rdy = go & win1;
  assign mem_req_val = mem_req_val_q & ~reset;
  assign resp0_val = resp_val_q[0] & ~reset;
  assign resp1_val = resp_val_q[1] & ~reset;
  assign mem_req.val = mem_req_val;
  assign mem_req.msg = mem_req_val ? req_buf : '0;
  assign mem_resp.rdy = mem_resp_rdy_q & ~reset;
  assign resp0.val = resp0_val;
  assign resp0.msg = resp0_val ? resp_buf : '0;
  assign resp1.val = resp1_val;
  assign resp1.msg = resp1_val ? resp_buf : '0;
  assign busy = busy_q & ~reset;
  // Remember reset for one cycle so grants stay off on the first cycle out of reset
  always_ff @(posedge clk) rst_d <= reset;
  // Transaction FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= 1'b0;
      prio <= p_init_prio;
      mem_req_val_q <= 1'b0;
      mem_resp_rdy_q <= 1'b0;
      resp_val_q <= 2'b00;
      busy_q <= 1'b0;
      req_buf <= '0;
      resp_buf <= '0;
    end else begin
      case (state)
        IDLE: if (req0.rdy | req1.rdy) begin
          req_buf <= req1.rdy ? req1.msg : req0.msg;
          grant_id <= req1.rdy;
          mem_req_val_q <= 1'b1;
          busy_q <= 1'b1;
          state <= SEND;
        end
        SEND: if (mem_req.rdy) begin
          mem_req_val_q <= 1'b0;
          mem_resp_rdy_q <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (mem_resp.val) begin
          resp_buf <= mem_resp.msg;
          mem_resp_rdy_q <= 1'b0;
          resp_val_q <= grant_id ? 2'b10 : 2'b01;
          state <= RESP;
        end
        RESP: if (grant_id ? resp1.rdy : resp0.rdy) begin
          resp_val_q <= 2'b00;
          busy_q <= 1'b0;
          if (!p_fixed_prio) prio <= ~grant_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lab3_cache_mem_port_arbiter.sv
// tb_lab3_cache_mem_port_arbiter: directed and random scoreboard bench for the memory port arbiter
module tb_lab3_cache_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic busy, f_busy;
  always #5 clk = ~clk;
  lab3_cache_mem_port_arbiter_if #(77) r0(), r1(), mq(), f_r0(), f_r1(), f_mq();
  lab3_cache_mem_port_arbiter_if #(47) s0(), s1(), ms(), f_s0(), f_s1(), f_ms();
  lab3_cache_mem_port_arbiter #(.p_fixed_prio(1'b0), .p_init_prio(1'b0)) dut (
    .clk(clk), .reset(reset), .req0(r0), .resp0(s0), .req1(r1), .resp1(s1),
    .mem_req(mq), .mem_resp(ms), .busy(busy));
  lab3_cache_mem_port_arbiter #(.p_fixed_prio(1'b1), .p_init_prio(1'b0)) dut_fx (
    .clk(clk), .reset(reset), .req0(f_r0), .resp0(f_s0), .req1(f_r1), .resp1(f_s1),
    .mem_req(f_mq), .mem_resp(f_ms), .busy(f_busy));
  typedef struct packed {logic p; logic [46:0] m;} exp_t;
  exp_t expq[$];
  logic [76:0] memq[$];
  logic ordq[$];
  int checks = 0, failures = 0, nresp = 0, delay = 0, n0, n1;
  int want[2];
  bit rnd = 1'b0, pending = 1'b0;
  logic [76:0] held, cur[2];
  logic [7:0] op = 8'h80;
  localparam logic [76:0] REQ1 = {3'd0, 8'h11, 32'h0000_1000, 2'd0, 32'd0};
  localparam logic [46:0] RSP1 = {3'd0, 8'h11, 2'd0, 2'd0, 32'hCAFE_F00D};
  localparam logic [76:0] REQ4 = {3'd1, 8'h44, 32'h0000_2000, 2'd0, 32'h1234_5678};
  localparam logic [46:0] RSP4 = {3'd1, 8'h44, 2'd0, 2'd0, 32'd0};
  localparam logic [76:0] REQ5 = {3'd0, 8'h55, 32'h0000_3000, 2'd0, 32'd0};
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [76:0] mk();
    op = op + 8'd1;
    return {3'($urandom_range(1, 0)), op, 32'($urandom), 2'($urandom_range(3, 0)), 32'($urandom)};
  endfunction
  function automatic logic [46:0] resp_of(input logic [76:0] m);
    return {m[76:74], m[73:66], 2'b00, m[33:32], m[31:0] ^ m[65:34]};
  endfunction
  task automatic accept(input int p);
    if (ordq.size() != 0) chk("grant_order", 80'(p), 80'(ordq.pop_front()));
    expq.push_back({p[0], resp_of(cur[p])});
    memq.push_back(cur[p]);
    want[p]--;
    cur[p] = mk();
  endtask
  task automatic take_resp(input logic p, input logic [46:0] m);
    exp_t e;
    chk("resp_dup", 80'(expq.size() != 0), 80'd1);
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("resp_port", 80'(p), 80'(e.p));
      chk("resp_msg", 80'(m), 80'(e.m));
    end
    nresp++;
  endtask
  task automatic run_cycle();
    @(negedge clk);
    r0.val = (want[0] > 0) && (!rnd || $urandom_range(1, 0) == 1);
    r1.val = (want[1] > 0) && (!rnd || $urandom_range(1, 0) == 1);
    r0.msg = cur[0];
    r1.msg = cur[1];
    mq.rdy = !rnd || $urandom_range(2, 0) != 0;
    s0.rdy = !rnd || $urandom_range(2, 0) != 0;
    s1.rdy = !rnd || $urandom_range(2, 0) != 0;
    if (pending) begin
      ms.val = (delay == 0) && (!rnd || $urandom_range(1, 0) == 1);
      ms.msg = resp_of(held);
      if (delay > 0) delay--;
    end else begin
      ms.val = rnd && $urandom_range(7, 0) == 0;
      ms.msg = {15'h0, 32'($urandom)};
    end
    #1;
    chk("one_grant", 80'(r0.rdy & r1.rdy), 80'd0);
    chk("one_resp", 80'(s0.val & s1.val), 80'd0);
    if (r0.val && r0.rdy) accept(0);
    if (r1.val && r1.rdy) accept(1);
    if (mq.val && mq.rdy) begin
      chk("memreq_dup", 80'(memq.size() != 0), 80'd1);
      if (memq.size() != 0) chk("memreq_msg", 80'(mq.msg), 80'(memq.pop_front()));
      pending = 1'b1;
      held = mq.msg;
      delay = rnd ? int'($urandom_range(3, 0)) : 0;
    end
    if (ms.val && ms.rdy) begin
      chk("stray_resp", 80'(pending), 80'd1);
      pending = 1'b0;
    end
    if (s0.val && s0.rdy) take_resp(1'b0, s0.msg);
    if (s1.val && s1.rdy) take_resp(1'b1, s1.msg);
  endtask
  initial begin
    reset = 1'b1;
    r0.val = 1'b1; r0.msg = REQ1; r1.val = 1'b0; r1.msg = '0;
    s0.rdy = 1'b1; s1.rdy = 1'b1; mq.rdy = 1'b1; ms.val = 1'b0; ms.msg = '0;
    f_r0.val = 1'b0; f_r0.msg = '0; f_r1.val = 1'b0; f_r1.msg = '0;
    f_s0.rdy = 1'b0; f_s1.rdy = 1'b0; f_mq.rdy = 1'b0; f_ms.val = 1'b0; f_ms.msg = '0;
    // reset and test 1: single port 0 read
    @(negedge clk); #1;
    chk("rst_rdy0", 80'(r0.rdy), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("post_rst_rdy0", 80'(r0.rdy), 80'd0);
    chk("post_rst_memval", 80'(mq.val), 80'd0);
    chk("post_rst_s0val", 80'(s0.val), 80'd0);
    @(negedge clk); #1;
    chk("t1_rdy0", 80'(r0.rdy), 80'd1);
    chk("t1_rdy1", 80'(r1.rdy), 80'd0);
    @(negedge clk); r0.val = 1'b0; #1;
    chk("t1_memval", 80'(mq.val), 80'd1);
    chk("t1_memmsg", 80'(mq.msg), 80'(REQ1));
    chk("t1_busy", 80'(busy), 80'd1);
    @(negedge clk); #1;
    chk("t1_memrdy", 80'(ms.rdy), 80'd1);
    @(negedge clk);
    @(negedge clk); ms.val = 1'b1; ms.msg = RSP1; #1;
    chk("t1_s0_early", 80'(s0.val), 80'd0);
    @(negedge clk); ms.val = 1'b0; #1;
    chk("t1_s0val", 80'(s0.val), 80'd1);
    chk("t1_s0msg", 80'(s0.msg), 80'(RSP1));
    chk("t1_s1val", 80'(s1.val), 80'd0);
    chk("t1_memrdy_off", 80'(ms.rdy), 80'd0);
    @(negedge clk); #1;
    chk("t1_idle", 80'(busy), 80'd0);
    chk("t1_s0_done", 80'(s0.val), 80'd0);
    // test 4: stalls on memory request and response
    mq.rdy = 1'b0;
    @(negedge clk); r0.val = 1'b1; r0.msg = REQ4; #1;
    chk("t4_acc", 80'(r0.rdy), 80'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin r0.val = 1'b0; r0.msg = '0; end
      #1;
      chk("t4_memval", 80'(mq.val), 80'd1);
      chk("t4_memmsg", 80'(mq.msg), 80'(REQ4));
      chk("t4_busy", 80'(busy), 80'd1);
    end
    @(negedge clk); mq.rdy = 1'b1; #1;
    chk("t4_memval_go", 80'(mq.val), 80'd1);
    @(negedge clk); ms.val = 1'b1; ms.msg = RSP4; s0.rdy = 1'b0; #1;
    chk("t4_memrdy", 80'(ms.rdy), 80'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin ms.val = 1'b0; ms.msg = 47'h7FFF_FFFF_FFFF; end
      #1;
      chk("t4_s0val", 80'(s0.val), 80'd1);
      chk("t4_s0msg", 80'(s0.msg), 80'(RSP4));
      chk("t4_busy_r", 80'(busy), 80'd1);
    end
    @(negedge clk); s0.rdy = 1'b1; #1;
    chk("t4_s0val_go", 80'(s0.val), 80'd1);
    @(negedge clk); #1;
    chk("t4_done", 80'(busy), 80'd0);
    // test 5: reset while waiting on memory
    @(negedge clk); r1.val = 1'b1; r1.msg = REQ5; #1;
    chk("t5_acc", 80'(r1.rdy), 80'd1);
    @(negedge clk); r1.val = 1'b0;
    @(negedge clk); #1;
    chk("t5_wait", 80'(ms.rdy), 80'd1);
    reset = 1'b1; #1;
    chk("t5_rst_memrdy", 80'(ms.rdy), 80'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("t5_busy", 80'(busy), 80'd0);
    chk("t5_memrdy", 80'(ms.rdy), 80'd0);
    chk("t5_memval", 80'(mq.val), 80'd0);
    chk("t5_s0val", 80'(s0.val), 80'd0);
    chk("t5_s1val", 80'(s1.val), 80'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ms.val = 1'b1; ms.msg = 47'h1_2345_6789; #1;
      chk("t5_stray_busy", 80'(busy), 80'd0);
      chk("t5_stray_s1", 80'(s1.val), 80'd0);
      chk("t5_stray_rdy", 80'(ms.rdy), 80'd0);
    end
    ms.val = 1'b0;
    // test 2: round-robin contention, three requests per port
    cur[0] = mk(); cur[1] = mk();
    want[0] = 3; want[1] = 3;
    for (int i = 0; i < 6; i++) ordq.push_back(i[0]);
    for (int i = 0; i < 200 && (want[0] + want[1] > 0 || expq.size() != 0); i++) run_cycle();
    chk("t2_done", 80'(ordq.size()), 80'd0);
    chk("t2_count", 80'(nresp), 80'd6);
    // test 3: fixed priority instance drains port 0 first
    f_mq.rdy = 1'b1; f_ms.val = 1'b1; f_ms.msg = 47'h1234; f_s0.rdy = 1'b1; f_s1.rdy = 1'b1;
    n0 = 3; n1 = 3;
    for (int i = 0; i < 6; i++) ordq.push_back(i >= 3);
    for (int i = 0; i < 100 && n0 + n1 > 0; i++) begin
      @(negedge clk);
      f_r0.val = n0 > 0; f_r1.val = n1 > 0; f_r0.msg = mk(); f_r1.msg = mk();
      #1;
      if (f_r0.rdy) begin
        if (ordq.size() != 0) chk("fixed_order", 80'd0, 80'(ordq.pop_front()));
        n0--;
      end
      if (f_r1.rdy) begin
        if (ordq.size() != 0) chk("fixed_order", 80'd1, 80'(ordq.pop_front()));
        n1--;
      end
    end
    @(negedge clk); f_r0.val = 1'b0; f_r1.val = 1'b0; f_ms.val = 1'b0;
    chk("fixed_done", 80'(ordq.size()), 80'd0);
    // test 6: random handshakes, 1000 transactions
    rnd = 1'b1; nresp = 0;
    want[0] = 500; want[1] = 500;
    for (int i = 0; i < 40000 && (want[0] + want[1] > 0 || expq.size() != 0); i++) run_cycle();
    chk("t6_count", 80'(nresp), 80'd1000);
    chk("t6_exp_left", 80'(expq.size()), 80'd0);
    chk("t6_mem_left", 80'(memq.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
